// File: rtl/fb_loader_if.sv
// Pixel stream in (valid/ready) and RAM write port out, bundled for the framebuffer loader.
interface fb_loader_if #(
  parameter int unsigned ADDR_W = 18
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        data;
  logic              wren;

  modport master (
    output in_data, in_valid,
    input  in_ready, wraddress, data, wren
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wraddress, data, wren
  );
endinterface

// File: rtl/fb_loader.sv
// Streams a raster-ordered byte frame into the VGA pixel RAM, tracking position and a checksum.
module fb_loader #(
  parameter int unsigned IMG_W     = 256,
  parameter int unsigned IMG_H     = 256,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  fb_loader_if.slave  bus,
  output logic        busy,
  output logic        done,
  output logic [15:0] checksum
);

  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [15:0]       checksum_q, checksum_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic [7:0]        data_q, data_d;
  logic              wren_q, wren_d;
  logic              accept;

  assign accept = (state_q == StLoad) && bus.in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= ADDR_W'(BASE_ADDR);
      col_q       <= '0;
      row_q       <= '0;
      checksum_q  <= '0;
      wraddress_q <= ADDR_W'(BASE_ADDR);
      data_q      <= '0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      col_q       <= col_d;
      row_q       <= row_d;
      checksum_q  <= checksum_d;
      wraddress_q <= wraddress_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    col_d       = col_q;
    row_d       = row_q;
    checksum_d  = checksum_q;
    wraddress_d = wraddress_q;
    data_d      = data_q;
    wren_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          ptr_d      = ADDR_W'(BASE_ADDR);
          col_d      = '0;
          row_d      = '0;
          checksum_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          wren_d      = 1'b1;
          data_d      = bus.in_data;
          wraddress_d = ptr_q;
          // Address advances by one per beat; raster order makes row*IMG_W+col implicit.
          ptr_d       = ptr_q + ADDR_W'(1);
          checksum_d  = checksum_q + 16'(bus.in_data);
          if (col_q == ColW'(IMG_W - 1)) begin
            col_d = '0;
            if (row_q == RowW'(IMG_H - 1)) begin
              row_d   = '0;
              state_d = StDone;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.wraddress = wraddress_q;
  assign bus.data      = data_q;
  assign bus.wren      = wren_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_fb_loader.sv
// Directed bench for fb_loader with a write scoreboard and a reference model of the load sequence.
module tb_fb_loader;

  localparam int unsigned IMG_W     = 4;
  localparam int unsigned IMG_H     = 2;
  localparam int unsigned ADDR_W    = 18;
  localparam int unsigned BASE_ADDR = 100;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] checksum;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Reference model state: 0 idle, 1 load, 2 done.
  int          m_state = 0;
  int          m_col = 0;
  int          m_row = 0;
  int          m_ptr = BASE_ADDR;
  logic [15:0] m_csum = '0;
  wr_t         exp_q[$];

  fb_loader_if #(.ADDR_W(ADDR_W)) bus ();

  fb_loader #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs 1ns after the edge.
  task automatic step(input logic rst, input logic st, input logic v, input logic [7:0] d);
    wr_t w;
    reset        = rst;
    start        = st;
    bus.in_valid = v;
    bus.in_data  = d;
    if (rst) begin
      m_state = 0; m_col = 0; m_row = 0; m_ptr = BASE_ADDR; m_csum = '0;
      exp_q.delete();
    end else begin
      case (m_state)
        0: if (st) begin
          m_state = 1; m_col = 0; m_row = 0; m_ptr = BASE_ADDR; m_csum = '0;
        end
        1: if (v) begin
          w.addr = ADDR_W'(m_ptr);
          w.data = d;
          exp_q.push_back(w);
          m_ptr++;
          m_csum = m_csum + 16'(d);
          if (m_col == IMG_W - 1) begin
            m_col = 0;
            if (m_row == IMG_H - 1) begin
              m_row = 0;
              m_state = 2;
            end else m_row++;
          end else m_col++;
        end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("done", 32'(done), 32'(m_state == 2));
    chk("checksum", 32'(checksum), 32'(m_csum));
    chk("wren", 32'(bus.wren), 32'(exp_q.size() != 0));
    if (bus.wren === 1'b1 && exp_q.size() != 0) begin
      w = exp_q.pop_front();
      chk("wraddress", 32'(bus.wraddress), 32'(w.addr));
      chk("data", 32'(bus.data), 32'(w.data));
    end
    if (rst) begin
      chk("rst_wraddress", 32'(bus.wraddress), BASE_ADDR);
      chk("rst_data", 32'(bus.data), 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  endtask

  initial begin
    int stall_done_at;
    reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;

    // Reset held with in_valid high.
    step(1'b1, 1'b0, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b0, 1'b1, 8'h55);  // idle: in_valid ignored

    // Full frame, back-to-back bytes 1..8.
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
    chk("frame1_done_last", 32'(done), 32'd1);
    chk("frame1_csum", 32'(checksum), 32'd36);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("frame1_done_cnt", done_cnt, 32'd1);
    chk("csum_hold", 32'(checksum), 32'd36);

    // Stalled frame: in_valid toggles, completes after 15 LOAD cycles.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    stall_done_at = -1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, (i % 2) == 0, 8'((i / 2) + 1));
      if (done === 1'b1 && stall_done_at < 0) stall_done_at = i;
    end
    chk("stall_done_at", 32'(stall_done_at), 32'd14);
    chk("stall_csum", 32'(checksum), 32'd36);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Checksum wrap: all 0xFF, then all 0x00.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("csum_ff", 32'(checksum), 32'h07F8);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("csum_00", 32'(checksum), 32'h0000);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Start pulsed mid-load is ignored.
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 8; i++) step(1'b0, i == 3, 1'b1, 8'(i + 20));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("restart_done_cnt", done_cnt, 32'd1);
    chk("restart_csum", 32'(checksum), 32'd196);

    // Reset after 5 beats, then a fresh frame from BASE_ADDR.
    done_cnt = 0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h33);
    chk("abort_no_done", done_cnt, 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h33);
    chk("abort_csum_cleared", 32'(checksum), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 10; i <= 17; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
    chk("reload_csum", 32'(checksum), 32'd108);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("reload_done_cnt", done_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_loader.md
# fb_loader

Framebuffer loader that fills the 8-bit pixel RAM scanned by the VGA drawing stage. It sits directly upstream of the display path: it accepts a raster-ordered byte stream from the processor/UART side over a valid/ready handshake and drives the RAM write port (`wraddress`, `data`, `wren`), while the drawing stage reads the other port. It also counts pixels and row/column position and keeps a running checksum so software can confirm a complete image was written.

## Interface
- `IMG_W`, default 256: image width in pixels, at least 1.
- `IMG_H`, default 256: image height in pixels, at least 1.
- `ADDR_W`, default 18: RAM address width. `BASE_ADDR + IMG_W*IMG_H` must be no more than 2^ADDR_W.
- `BASE_ADDR`, default 0: RAM address of pixel (0,0).

Ports (clock and reset first):
- `clk` in, 1: single clock for all logic.
- `reset` in, 1: synchronous, active-high.
- `start` in, 1: begin loading one frame. Sampled only in IDLE.
- `in_data` in, 8: pixel byte, raster order, row 0 column 0 first.
- `in_valid` in, 1: `in_data` is valid.
- `in_ready` out, 1: the loader accepts a beat this cycle.
- `wraddress` out, ADDR_W: RAM write address.
- `data` out, 8: RAM write data.
- `wren` out, 1: RAM write enable.
- `busy` out, 1: a frame load is in progress.
- `done` out, 1: one-cycle pulse when a frame load completes.
- `checksum` out, 16: mod-2^16 sum of all bytes in the last or current frame.

## Operation
- States are IDLE, LOAD and DONE.
- IDLE to LOAD: on a clock edge with `start`=1. On the same edge, clear `col`, `row` and `checksum`, and load the address pointer with BASE_ADDR.
- In LOAD, `in_ready` is 1. Outside LOAD it is 0.
- A beat is accepted on a clock edge where `in_valid && in_ready` is true.
- On each accepted beat, on the same edge:
  - `data` gets `in_data`, `wraddress` gets the pointer, and `wren` is set to 1.
  - The pointer increments by 1. The address is built incrementally with no multiplier.
  - `checksum` gets `checksum + in_data`, truncated to 16 bits.
  - `col` increments. When `col` is IMG_W-1, it wraps to 0 and `row` increments.
- When there is no accepted beat, `wren` registers to 0. `wraddress` and `data` hold their values.
- Last beat: the beat accepted with `row`=IMG_H-1 and `col`=IMG_W-1. On that edge the state moves from LOAD to DONE.
- In DONE: `done`=1 for exactly that one cycle. The state returns to IDLE on the next edge.
- `busy` = (state != IDLE).
- `start` while in LOAD or DONE is ignored and does not restart the load.
- `in_valid` while not in LOAD is ignored. No beat is consumed, so upstream must hold its data.
- `checksum` holds its value after DONE until the next `start`.
- Reset mid-load: on the reset edge, all state clears. The partially written RAM contents are not touched. No `done` is produced for the aborted frame.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `wren`, `busy`, `done` = 0.
  - `wraddress` = BASE_ADDR.
  - `data` = 0.
  - `checksum` = 0.
  - Internal `col` and `row` = 0.
- `start` sampled at edge E: `busy` and `in_ready` are 1 from edge E onward. The first beat can be accepted at edge E+1.
- Write latency: a beat accepted at edge N is presented as `wren`=1 with its address and data during the cycle after edge N. The RAM captures it at edge N+1.
- Throughput: one beat per clock with `in_valid` held high. A full frame takes IMG_W*IMG_H cycles.
- Stalls (`in_valid`=0) insert cycles with `wren`=0. There is no buffering, so there is no full or empty condition.
- Last beat accepted at edge N:
  - `in_ready` = 0 and `done` = 1 during cycle N+1. This is the same cycle that shows the last write.
  - `busy` = 0 from edge N+1 onward.
- A new `start` is accepted at edge N+2 at the earliest.
- IMG_W=1 or IMG_H=1 must work. Column and row wrap happen on every beat where applicable.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `in_valid`=1. Required: all outputs at their reset values, `in_ready`=0, no `wren` pulses.
- **Full frame at IMG_W=4, IMG_H=2, BASE_ADDR=100, bytes 1..8 back-to-back.** Required:
  - 8 writes to addresses 100..107 with data 1..8 on consecutive cycles.
  - `done` high for one cycle, aligned with the address-107 write.
  - `checksum` = 36.
- **Stalls:** same frame with `in_valid` toggling 1,0,1,0,… Required:
  - `wren` gaps match the stall cycles.
  - Addresses are contiguous 100..107 with no duplicates.
  - Frame completes after 15 cycles of LOAD.
- **Checksum wrap:** 4x2 frame of all 0xFF bytes, then a second `start` with all 0x00 bytes. Required: `checksum` = 0x07F8 after the first frame and 0x0000 after the second.
- **Start during load:** pulse `start` at beat 3. Required: address sequence is unaffected, and exactly one `done` pulse occurs.
- **Reset mid-load:** assert `reset` after 5 beats, then `start` again with a new frame. Required: no `done` before the reset, and the new frame writes from BASE_ADDR with `checksum` counted from 0.
